smem_req_arbiter: RTL and testbench

Shares the single paired-address DRAM request path (k/l cache-line pair, read-number tag) between up to `NUM_REQ` requesters in the 200 MHz core domain. It enforces a credit limit on outstanding pairs so the 16-deep response FIFOs never overflow. It records the requester order and routes each returning k/l response pair back to the requester that issued it. It sits between the SMEM pipeline lanes (and the polling/read-load sequencer) and the 2-write request FIFO / response FIFO pair.

---
 rtl/smem_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_smem_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smem_req_arbiter.sv
// Credit-limited arbiter for the paired k/l DRAM request path, with in-order response routing.
// Define SMEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module smem_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 58,
   parameter int TAG_W   = 6,
   parameter int MAX_OUT = 8
) (
   input  logic                      CLK_200M,
   input  logic                      spl_reset,
   input  logic                      stall,
   input  logic                      quiesce,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_k,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_l,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   output logic                      fifo_wr_en,
   output logic [ADDR_W-1:0]         fifo_addr_1,
   output logic [ADDR_W-1:0]         fifo_addr_2,
   output logic [TAG_W-1:0]          fifo_tag,
   input  logic                      rsp_valid,
   input  logic [511:0]              rsp_k,
   input  logic [511:0]              rsp_l,
   output logic [NUM_REQ-1:0]        rsp_out_valid,
   output logic [511:0]              rsp_out_k,
   output logic [511:0]              rsp_out_l,
   output logic [$clog2(MAX_OUT):0]  outstanding,
   output logic                      idle,
   output logic                      err_unexp
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int PW = $clog2(MAX_OUT);
   localparam int OW = PW + 1;

   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  addr1_q, addr1_d;
   logic [ADDR_W-1:0]  addr2_q, addr2_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [NUM_REQ-1:0] rov_q, rov_d;
   logic [511:0]       rok_q, rok_d;
   logic [511:0]       rol_q, rol_d;
   logic [OW-1:0]      out_q, out_d;
   logic               err_q, err_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [IW-1:0]      id_mem_q [MAX_OUT];
   logic [IW-1:0]      id_mem_d [MAX_OUT];

   logic               elig;
   logic               found;
   logic [IW-1:0]      gnt_idx;
   logic               pop;

`ifndef SMEM_ARB_FIXED_PRIO_EN
   logic [IW-1:0]      last_q, last_d;
`endif

   assign elig = !spl_reset && !stall && !quiesce && (out_q < OW'(MAX_OUT));
   assign pop  = rsp_valid && (out_q != '0);

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      if (elig) begin
`ifdef SMEM_ARB_FIXED_PRIO_EN
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k]) begin
               found   = 1'b1;
               gnt_idx = IW'(k);
            end
         end
`else
         // Search begins one past the last winner and wraps.
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
               found   = 1'b1;
               gnt_idx = IW'((int'(last_q) + k) % NUM_REQ);
            end
         end
`endif
      end
   end

   assign req_ready = found ? (NUM_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      wr_en_d  = found;
      addr1_d  = addr1_q;
      addr2_d  = addr2_q;
      tag_d    = tag_q;
      rov_d    = '0;
      rok_d    = rok_q;
      rol_d    = rol_q;
      out_d    = out_q;
      err_d    = err_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      id_mem_d = id_mem_q;
`ifndef SMEM_ARB_FIXED_PRIO_EN
      last_d   = last_q;
`endif
      if (found) begin
         addr1_d  = req_addr_k[gnt_idx*ADDR_W +: ADDR_W];
         addr2_d  = req_addr_l[gnt_idx*ADDR_W +: ADDR_W];
         tag_d    = req_tag[gnt_idx*TAG_W +: TAG_W];
         id_mem_d[wr_ptr_q] = gnt_idx;
         wr_ptr_d = wr_ptr_q + 1'b1;
`ifndef SMEM_ARB_FIXED_PRIO_EN
         last_d   = gnt_idx;
`endif
      end
      if (pop) begin
         rov_d    = NUM_REQ'(1) << id_mem_q[rd_ptr_q];
         rok_d    = rsp_k;
         rol_d    = rsp_l;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (rsp_valid && (out_q == '0)) begin
         err_d = 1'b1;
      end
      unique case ({found, pop})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge CLK_200M or posedge spl_reset) begin
      if (spl_reset) begin
         wr_en_q  <= 1'b0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         tag_q    <= '0;
         rov_q    <= '0;
         rok_q    <= '0;
         rol_q    <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < MAX_OUT; i++) id_mem_q[i] <= '0;
`ifndef SMEM_ARB_FIXED_PRIO_EN
         last_q   <= IW'(NUM_REQ - 1);
`endif
      end else begin
         wr_en_q  <= wr_en_d;
         addr1_q  <= addr1_d;
         addr2_q  <= addr2_d;
         tag_q    <= tag_d;
         rov_q    <= rov_d;
         rok_q    <= rok_d;
         rol_q    <= rol_d;
         out_q    <= out_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         id_mem_q <= id_mem_d;
`ifndef SMEM_ARB_FIXED_PRIO_EN
         last_q   <= last_d;
`endif
      end
   end

   assign fifo_wr_en    = wr_en_q;
   assign fifo_addr_1   = addr1_q;
   assign fifo_addr_2   = addr2_q;
   assign fifo_tag      = tag_q;
   assign rsp_out_valid = rov_q;
   assign rsp_out_k     = rok_q;
   assign rsp_out_l     = rol_q;
   assign outstanding   = out_q;
   assign err_unexp     = err_q;
   assign idle          = (out_q == '0) && !wr_en_q;

endmodule

// File: tb/tb_smem_req_arbiter.sv
// Directed bench for smem_req_arbiter with a small reference model of grants,
// credits and the requester-order queue.
module tb_smem_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 58;
   localparam int TW = 6;
   localparam int MO = 8;

   logic            clk = 1'b0;
   logic            spl_reset;
   logic            stall, quiesce;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*AW-1:0] req_addr_k, req_addr_l;
   logic [N*TW-1:0] req_tag;
   logic            fifo_wr_en;
   logic [AW-1:0]   fifo_addr_1, fifo_addr_2;
   logic [TW-1:0]   fifo_tag;
   logic            rsp_valid;
   logic [511:0]    rsp_k, rsp_l;
   logic [N-1:0]    rsp_out_valid;
   logic [511:0]    rsp_out_k, rsp_out_l;
   logic [3:0]      outstanding;
   logic            idle, err_unexp;

   smem_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TAG_W(TW), .MAX_OUT(MO)) dut (
      .CLK_200M(clk), .spl_reset(spl_reset), .stall(stall), .quiesce(quiesce),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_k(req_addr_k), .req_addr_l(req_addr_l), .req_tag(req_tag),
      .fifo_wr_en(fifo_wr_en), .fifo_addr_1(fifo_addr_1),
      .fifo_addr_2(fifo_addr_2), .fifo_tag(fifo_tag),
      .rsp_valid(rsp_valid), .rsp_k(rsp_k), .rsp_l(rsp_l),
      .rsp_out_valid(rsp_out_valid), .rsp_out_k(rsp_out_k), .rsp_out_l(rsp_out_l),
      .outstanding(outstanding), .idle(idle), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] ak(input int i);
      return AW'(64'h0abc_0000_1000 + 64'(i));
   endfunction
   function automatic logic [AW-1:0] al(input int i);
      return AW'(64'h0def_0000_2000 + 64'(i * 3));
   endfunction
   function automatic logic [TW-1:0] tg(input int i);
      return TW'(i + 5);
   endfunction

   int      m_out = 0;
   int      m_last = N - 1;
   int      idq[$];
   bit      m_err = 0;
   int      wr_cnt = 0;
   logic [31:0] dat = 32'h1000_0000;

   task automatic tick();
      int g;
      int j;
      int h;
      bit p;
      logic [N-1:0] eg;
      logic [511:0] ek, el;
      dat   = dat + 32'h11;
      rsp_k = {16{dat}};
      rsp_l = ~{16{dat}};
      #1;
      g = -1;
      if (!stall && !quiesce && m_out < MO) begin
         for (int k = 1; k <= N; k++) begin
`ifdef SMEM_ARB_FIXED_PRIO_EN
            j = k - 1;
`else
            j = (m_last + k) % N;
`endif
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", req_ready, eg);
      p  = rsp_valid && (m_out > 0);
      h  = p ? idq[0] : 0;
      ek = rsp_k;
      el = rsp_l;
      @(posedge clk);
      #1;
      if (p) begin
         void'(idq.pop_front());
         m_out--;
      end else if (rsp_valid) begin
         m_err = 1'b1;
      end
      if (g >= 0) begin
         idq.push_back(g);
         m_out++;
         m_last = g;
      end
      chk("wr_en", fifo_wr_en, g >= 0);
      if (fifo_wr_en) wr_cnt++;
      if (g >= 0) begin
         chk("addr1", fifo_addr_1, ak(g));
         chk("addr2", fifo_addr_2, al(g));
         chk("tag", fifo_tag, tg(g));
      end
      eg = '0;
      if (p) eg[h] = 1'b1;
      chk("rsp_out_valid", rsp_out_valid, eg);
      if (p) begin
         chk("rsp_out_k", rsp_out_k, ek);
         chk("rsp_out_l", rsp_out_l, el);
      end
      chk("outstanding", outstanding, m_out);
      chk("err_unexp", err_unexp, m_err);
      chk("idle", idle, (m_out == 0) && (g < 0));
   endtask

   int saved;
   int w0;
   int g1;
   logic [N-1:0] exp_rr;

   initial begin
      spl_reset = 1'b1;
      stall = 0; quiesce = 0; rsp_valid = 0;
      req_valid = '1;
      rsp_k = '0; rsp_l = '0;
      for (int i = 0; i < N; i++) begin
         req_addr_k[i*AW +: AW] = ak(i);
         req_addr_l[i*AW +: AW] = al(i);
         req_tag[i*TW +: TW]    = tg(i);
      end
      #1;
      chk("rst_ready", req_ready, 0);
      @(posedge clk); #1;
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_rov", rsp_out_valid, 0);
      chk("rst_out", outstanding, 0);
      chk("rst_idle", idle, 1);
      chk("rst_err", err_unexp, 0);
      chk("rst_addr", fifo_addr_1, 0);
      chk("rst_ready2", req_ready, 0);
      spl_reset = 1'b0;

      // All requesters, responses 3 cycles after each write
      for (int n = 0; n < 16; n++) begin
         rsp_valid = (n >= 3);
         tick();
         chk("out_le3", outstanding <= 3, 1);
      end
      req_valid = '0;
      rsp_valid = 1;
      for (int n = 0; n < 3; n++) tick();
      rsp_valid = 0;
      chk("drain_idle", idle, 1);

      // Requester 2 alone, no responses: credit limit
      req_valid = 4'b0100;
      w0 = wr_cnt;
      for (int n = 0; n < 12; n++) tick();
      chk("credit_writes", wr_cnt - w0, 8);
      chk("credit_out", outstanding, 8);
      #1;
      chk("credit_ready", req_ready, 0);
      rsp_valid = 1;
      tick();
      rsp_valid = 0;
      tick();
      chk("credit_regrant", fifo_wr_en, 1);
      chk("credit_out2", outstanding, 8);

      // Full: continuous responses and requests, order tracked by the model
      req_valid = '1;
      rsp_valid = 1;
      for (int n = 0; n < 20; n++) begin
         tick();
         chk("full_out_ge7", outstanding >= 7, 1);
      end

      // Stall: no writes, responses still routed
      stall = 1;
      saved = m_last;
      w0 = wr_cnt;
      for (int n = 0; n < 5; n++) tick();
      chk("stall_writes", wr_cnt - w0, 0);
      stall = 0;
      rsp_valid = 0;
      #1;
      exp_rr = '0;
`ifdef SMEM_ARB_FIXED_PRIO_EN
      exp_rr[0] = 1'b1;
`else
      exp_rr[(saved + 1) % N] = 1'b1;
`endif
      chk("stall_resume", req_ready, exp_rr);
      tick();

      // Drain, then quiesce with 3 outstanding
      req_valid = '0;
      rsp_valid = 1;
      for (int n = 0; n < 12 && m_out > 0; n++) tick();
      rsp_valid = 0;
      chk("q_empty", outstanding, 0);
      req_valid = '1;
      for (int n = 0; n < 3; n++) tick();
      chk("q_out3", outstanding, 3);
      quiesce = 1;
      rsp_valid = 1;
      for (int n = 0; n < 3; n++) tick();
      chk("q_idle", idle, 1);
      tick();
      chk("q_err", err_unexp, 1);
      chk("q_no_rov", rsp_out_valid, 0);
      quiesce = 0;
      rsp_valid = 0;

      // Asynchronous reset with 5 outstanding
      for (int n = 0; n < 5; n++) tick();
      chk("r_out5", outstanding, 5);
      #2 spl_reset = 1'b1;
      #1;
      chk("ar_wr_en", fifo_wr_en, 0);
      chk("ar_out", outstanding, 0);
      chk("ar_idle", idle, 1);
      chk("ar_err", err_unexp, 0);
      chk("ar_ready", req_ready, 0);
      chk("ar_tag", fifo_tag, 0);
      m_out = 0; m_last = N - 1; m_err = 0;
      idq.delete();
      @(posedge clk); #1;
      chk("ar_ready_held", req_ready, 0);
      spl_reset = 1'b0;
      #1;
      chk("ar_first", req_ready, 4'b0001);
      tick();

      // Requesters 1 and 3 competing
      req_valid = 4'b1010;
      rsp_valid = 1;
      g1 = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (fifo_wr_en && fifo_addr_1 == ak(1)) g1++;
      end
`ifdef SMEM_ARB_FIXED_PRIO_EN
      chk("prio_g1", g1, 6);
`else
      chk("rr_g1", g1, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
